regfile_wb_ctrl: RTL and testbench

- Writeback controller in front of the register file's single write port.
- Arbitrates two writeback sources (ALU, load unit) with round-robin fairness.
- Drives a registered write command into the register file; writes to x0 are dropped.
- Keeps a per-register pending-write scoreboard so issue logic can stall on RAW hazards.

---
 rtl/rv32_pkg.sv | 11 +
 rtl/regfile_wb_ctrl_rr_arb2.sv | 26 ++
 rtl/regfile_wb_ctrl.sv | 93 +++++++++
 tb/tb_regfile_wb_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 register-file constants and the register-index type used by
// the writeback path.
package rv32_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  typedef logic [AW-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = '0;
endpackage

// File: rtl/regfile_wb_ctrl_rr_arb2.sv
// Two-request round-robin arbiter. The pointer remembers which source should
// win the next tie and flips toward the loser after every grant.
module rr_arb2 (
  input  logic clock,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  output logic grant0,
  output logic grant1
);
  import rv32_pkg::*;

  logic prefer1;

  always_comb begin
    grant0 = req0 & (~req1 | ~prefer1);
    grant1 = req1 & (~req0 | prefer1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      prefer1 <= 1'b0;
    else if (grant0 | grant1)
      prefer1 <= grant0;
  end
endmodule

// File: rtl/regfile_wb_ctrl.sv
// Writeback controller: arbitrates ALU and load writebacks onto the single
// register-file write port and tracks pending writes per register.
module regfile_wb_ctrl #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req0_valid,
  input  logic [AW-1:0]   req0_rd,
  input  logic [XLEN-1:0] req0_data,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [AW-1:0]   req1_rd,
  input  logic [XLEN-1:0] req1_data,
  output logic            req1_ready,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            rf_write,
  output logic [AW-1:0]   rf_write_reg,
  output logic [XLEN-1:0] rf_write_data,
  output logic [NREG-1:0] busy,
  output logic            wb_err
);
  import rv32_pkg::*;

  logic            grant0, grant1;
  logic            vld_p0;
  logic [AW-1:0]   rd_p0;
  logic [XLEN-1:0] data_p0;
  logic            nz_p0;
  logic [NREG-1:0] set_vec, clr_vec, busy_next;
  logic            err_hit;

  logic            vld_p1;
  logic [AW-1:0]   rd_p1;
  logic [XLEN-1:0] data_p1;

  rr_arb2 u_arb (
    .clock  (clock),
    .reset  (reset),
    .req0   (req0_valid),
    .req1   (req1_valid),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Stage p0: select the winner and compute scoreboard updates
  always_comb begin
    vld_p0  = grant0 | grant1;
    rd_p0   = grant1 ? req1_rd   : req0_rd;
    data_p0 = grant1 ? req1_data : req0_data;
    nz_p0   = vld_p0 && (rd_p0 != AW'(REG_ZERO));
    set_vec = '0;
    clr_vec = '0;
    if (issue_valid && issue_rd != AW'(REG_ZERO))
      set_vec[issue_rd] = 1'b1;
    if (nz_p0)
      clr_vec[rd_p0] = 1'b1;
    // Set is applied after clear so a newer producer keeps the register busy
    busy_next    = (busy & ~clr_vec) | set_vec;
    busy_next[0] = 1'b0;
    err_hit      = nz_p0 && !busy[rd_p0];
  end

  // Stage p1: registered write command and scoreboard state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      rd_p1   <= '0;
      data_p1 <= '0;
      busy    <= '0;
      wb_err  <= 1'b0;
    end else begin
      vld_p1 <= nz_p0;
      if (vld_p0) begin
        rd_p1   <= rd_p0;
        data_p1 <= data_p0;
      end
      busy <= busy_next;
      if (err_hit)
        wb_err <= 1'b1;
    end
  end

  assign rf_write      = vld_p1;
  assign rf_write_reg  = rd_p1;
  assign rf_write_data = data_p1;
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed and randomized bench for regfile_wb_ctrl with a behavioural
// reference model of arbitration, write port and pending-write scoreboard.
module tb_regfile_wb_ctrl;
  logic        clock = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid, issue_valid;
  logic [4:0]  req0_rd, req1_rd, issue_rd;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        rf_write;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data;
  logic [31:0] busy;
  logic        wb_err;

  int checks = 0;
  int errors = 0;

  regfile_wb_ctrl dut (
    .clock         (clock),
    .reset         (reset),
    .req0_valid    (req0_valid),
    .req0_rd       (req0_rd),
    .req0_data     (req0_data),
    .req0_ready    (req0_ready),
    .req1_valid    (req1_valid),
    .req1_rd       (req1_rd),
    .req1_data     (req1_data),
    .req1_ready    (req1_ready),
    .issue_valid   (issue_valid),
    .issue_rd      (issue_rd),
    .rf_write      (rf_write),
    .rf_write_reg  (rf_write_reg),
    .rf_write_data (rf_write_data),
    .busy          (busy),
    .wb_err        (wb_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #1;
  endtask

  // Reference model state
  bit          m_busy [32];
  bit          m_err;
  int          m_pref;
  bit          m_wr;
  logic [4:0]  m_reg;
  logic [31:0] m_data;

  function automatic logic [31:0] pack_busy();
    logic [31:0] v = '0;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  initial begin
    int winner;
    logic [4:0] wrd;
    bit g0, g1;

    reset = 1'b1;
    req0_valid = 0; req1_valid = 0; issue_valid = 0;
    req0_rd = 0; req1_rd = 0; issue_rd = 0;
    req0_data = 0; req1_data = 0;
    repeat (2) @(negedge clock);
    check("rst_rf_write", rf_write, 0);
    check("rst_reg", rf_write_reg, 0);
    check("rst_data", rf_write_data, 0);
    check("rst_busy", busy, 0);
    check("rst_err", wb_err, 0);
    reset = 1'b0;

    // Single ALU write
    issue_valid = 1; issue_rd = 5;
    tick();
    issue_valid = 0;
    check("t1_busy5_set", busy, 32'h20);
    req0_valid = 1; req0_rd = 5; req0_data = 32'hDEADBEEF;
    #1 check("t1_ready0", req0_ready, 1);
    tick();
    req0_valid = 0;
    check("t1_wr", rf_write, 1);
    check("t1_reg", rf_write_reg, 5);
    check("t1_data", rf_write_data, 32'hDEADBEEF);
    check("t1_busy_clr", busy, 0);
    tick();
    check("t1_idle_wr", rf_write, 0);
    check("t1_hold_reg", rf_write_reg, 5);
    check("t1_hold_data", rf_write_data, 32'hDEADBEEF);

    // Contention after reset
    pulse_reset();
    issue_valid = 1; issue_rd = 3; tick();
    issue_rd = 4; tick();
    issue_valid = 0;
    req0_valid = 1; req0_rd = 3; req0_data = 32'h33;
    req1_valid = 1; req1_rd = 4; req1_data = 32'h44;
    #1 check("t2_ready0_first", {req1_ready, req0_ready}, 2'b01);
    tick();
    check("t2_wr3", rf_write, 1);
    check("t2_reg3", rf_write_reg, 3);
    check("t2_ready1_next", {req1_ready, req0_ready}, 2'b10);
    tick();
    req0_valid = 0; req1_valid = 0;
    check("t2_wr4", rf_write, 1);
    check("t2_reg4", rf_write_reg, 4);
    check("t2_data4", rf_write_data, 32'h44);
    check("t2_busy", busy, 0);

    // Write to x0 is accepted but dropped
    req1_valid = 1; req1_rd = 0; req1_data = 32'h1234;
    #1 check("x0_ready1", req1_ready, 1);
    tick();
    req1_valid = 0;
    check("x0_wr", rf_write, 0);
    check("x0_busy", busy, 0);
    check("x0_err", wb_err, 0);

    // Sustained contention alternates
    req0_valid = 1; req0_rd = 1; req0_data = 32'hA0;
    req1_valid = 1; req1_rd = 2; req1_data = 32'hB0;
    for (int i = 0; i < 6; i++) begin
      #1 check($sformatf("sus_grant%0d", i), {req1_ready, req0_ready},
               (i % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      check($sformatf("sus_wr%0d", i), rf_write, 1);
      check($sformatf("sus_reg%0d", i), rf_write_reg, (i % 2 == 0) ? 1 : 2);
      check($sformatf("sus_data%0d", i), rf_write_data, (i % 2 == 0) ? 32'hA0 : 32'hB0);
    end
    req0_valid = 0; req1_valid = 0;

    // Set and clear of the same register on one edge
    issue_valid = 1; issue_rd = 7; tick();
    req0_valid = 1; req0_rd = 7; req0_data = 32'h77;
    #1 check("col_ready0", req0_ready, 1);
    tick();
    issue_valid = 0; req0_valid = 0;
    check("col_wr", rf_write, 1);
    check("col_busy7", busy[7], 1);

    // Writeback to a non-busy register sets the sticky error
    pulse_reset();
    check("err_clear", wb_err, 0);
    req0_valid = 1; req0_rd = 9; req0_data = 32'h99;
    tick();
    req0_valid = 0;
    check("err_set", wb_err, 1);
    repeat (3) tick();
    check("err_sticky", wb_err, 1);

    // Asynchronous reset while a write is on the port
    issue_valid = 1;
    for (int r = 8; r <= 12; r++) begin
      issue_rd = 5'(r);
      tick();
    end
    issue_valid = 0;
    req0_valid = 1; req0_rd = 12; req0_data = 32'hC;
    tick();
    req0_valid = 0;
    check("ar_pre_wr", rf_write, 1);
    check("ar_pre_busy", busy, 32'h0000_0F00);
    #2 reset = 1'b1;
    #1;
    check("ar_wr", rf_write, 0);
    check("ar_busy", busy, 0);
    check("ar_err", wb_err, 0);
    check("ar_reg", rf_write_reg, 0);
    reset = 1'b0;
    req0_valid = 1; req0_rd = 8; req1_valid = 1; req1_rd = 9;
    #1 check("ar_first_grant", {req1_ready, req0_ready}, 2'b01);
    tick();
    req0_valid = 0; req1_valid = 0;

    // Randomized traffic against the reference model
    pulse_reset();
    for (int i = 0; i < 32; i++) m_busy[i] = 0;
    m_err = 0; m_pref = 0; m_wr = 0; m_reg = 0; m_data = 0;
    g0 = 1; g1 = 1;
    for (int c = 0; c < 400; c++) begin
      check("rnd_wr", rf_write, m_wr);
      if (m_wr) begin
        check("rnd_reg", rf_write_reg, m_reg);
        check("rnd_data", rf_write_data, m_data);
      end
      check("rnd_busy", busy, pack_busy());
      check("rnd_err", wb_err, m_err);

      if (!req0_valid || g0) begin
        req0_valid = ($urandom % 3) != 0;
        req0_rd = 5'($urandom % 8);
        req0_data = $urandom;
      end
      if (!req1_valid || g1) begin
        req1_valid = ($urandom % 3) != 0;
        req1_rd = 5'($urandom % 8);
        req1_data = $urandom;
      end
      issue_valid = $urandom % 2;
      issue_rd = 5'($urandom % 8);

      if (req0_valid && req1_valid) winner = m_pref;
      else if (req0_valid) winner = 0;
      else if (req1_valid) winner = 1;
      else winner = -1;
      g0 = (winner == 0);
      g1 = (winner == 1);
      #1 check("rnd_ready", {req1_ready, req0_ready}, {g1, g0});

      m_wr = 0;
      if (winner >= 0) begin
        wrd = (winner == 0) ? req0_rd : req1_rd;
        m_reg = wrd;
        m_data = (winner == 0) ? req0_data : req1_data;
        m_pref = 1 - winner;
        if (wrd != 0) begin
          m_wr = 1;
          if (!m_busy[wrd]) m_err = 1;
          m_busy[wrd] = 0;
        end
      end
      if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
